// File: rtl/alu_operand_stage.sv
// rtl/alu_operand_stage.sv - R-type decode/issue stage with register file, scoreboard and writeback bypass
module alu_operand_stage #(
  parameter int          DATA_W     = 32,
  parameter logic [5:0]  NOOP_FUNCT = 6'h2C
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic              out_cin,
  output logic [5:0]        out_funct,
  output logic [4:0]        out_rd,
  output logic              out_wb,
  input  logic              wb_en,
  input  logic [4:0]        wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              illegal
);

  logic [DATA_W-1:0] regs [32];
  logic [31:0]       pending;
  logic [31:0]       pending_nxt;

  logic [5:0] opcode, funct;
  logic [4:0] rs, rt, rd;
  logic       legal, hazard, issue, issue_wb, accept;
  logic [DATA_W-1:0] rd_a, rd_b;
  logic       unused_shamt;

  assign opcode = in_instr[31:26];
  assign rs     = in_instr[25:21];
  assign rt     = in_instr[20:16];
  assign rd     = in_instr[15:11];
  assign funct  = in_instr[5:0];
  assign unused_shamt = ^in_instr[10:6];

  always_comb begin
    legal = 1'b0;
    if (opcode == 6'd0) begin
      case (funct)
        6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2C: legal = 1'b1;
        default: legal = 1'b0;
      endcase
    end
  end

  // A register whose writeback lands this cycle is no longer a hazard
  function automatic logic busy(input logic [4:0] r);
    return (r != 5'd0) && pending[r] && !(wb_en && (wb_addr == r));
  endfunction

  function automatic logic [DATA_W-1:0] read_reg(input logic [4:0] r);
    if (r == 5'd0)
      return '0;
    else if (wb_en && (wb_addr == r))
      return wb_data;
    else
      return regs[r];
  endfunction

  assign hazard   = legal && (busy(rs) || busy(rt) || busy(rd));
  assign in_ready = (!out_valid || out_ready) && !hazard;
  assign accept   = in_valid && in_ready;
  assign issue    = accept && legal;
  assign issue_wb = (rd != 5'd0) && (funct != NOOP_FUNCT);
  assign rd_a     = read_reg(rs);
  assign rd_b     = read_reg(rt);
  assign out_cin  = 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (wb_en && (wb_addr != 5'd0)) begin
      regs[wb_addr] <= wb_data;
    end
  end

  // Set after clear so a same-cycle issue to a register being written back wins
  always_comb begin
    pending_nxt = pending;
    if (wb_en) pending_nxt[wb_addr] = 1'b0;
    if (issue && issue_wb) pending_nxt[rd] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
      illegal <= 1'b0;
    end else begin
      pending <= pending_nxt;
      if (accept && !legal) illegal <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_a     <= '0;
      out_b     <= '0;
      out_funct <= '0;
      out_rd    <= '0;
      out_wb    <= 1'b0;
    end else if (issue) begin
      out_valid <= 1'b1;
      out_a     <= rd_a;
      out_b     <= rd_b;
      out_funct <= funct;
      out_rd    <= rd;
      out_wb    <= issue_wb;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
